// File: rtl/boot_monitor_pkg.sv
// Shared command/reply codes, state encodings and helpers for the boot monitor.
package boot_monitor_pkg;

    localparam logic [7:0] CmdLoad = 8'h4C;
    localparam logic [7:0] CmdDump = 8'h44;
    localparam logic [7:0] CmdRun  = 8'h52;

    localparam logic [7:0] RspAck  = 8'h2E;
    localparam logic [7:0] RspErr  = 8'h3F;
    localparam logic [7:0] RspHalt = 8'h48;

    typedef enum logic [3:0] {
        StIdle,
        StAddrHi,
        StAddrLo,
        StLen,
        StLoad,
        StDumpRd,
        StDumpW1,
        StDumpW2,
        StDumpTx,
        StRunStart,
        StRunning,
        StTxWait,
        StSum
    } state_e;

    typedef enum logic [1:0] {
        TxIdle,
        TxWait,
        TxGap
    } tx_state_e;

    // A length byte of zero stands for a full 256-byte block.
    function automatic logic [8:0] decode_len(input logic [7:0] n);
        return (n == 8'd0) ? 9'd256 : {1'b0, n};
    endfunction

endpackage

// File: rtl/mon_tx.sv
// Single-byte transmit slot: waits for the UART to go idle, strobes one byte,
// then holds a gap cycle so the busy flag has time to rise before the next byte.
module mon_tx
    import boot_monitor_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [7:0] tx_data,
    input  logic       is_transmitting,
    output logic [7:0] tx_byte,
    output logic       transmit,
    output logic       done
);

    tx_state_e  state_q, state_d;
    logic [7:0] data_q, data_d;
    logic [7:0] tx_byte_q, tx_byte_d;
    logic       transmit_q, transmit_d;
    logic       done_q, done_d;

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        tx_byte_d  = 8'h00;
        transmit_d = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            TxIdle: begin
                if (req) begin
                    data_d  = tx_data;
                    state_d = TxWait;
                end
            end
            TxWait: begin
                if (!is_transmitting) begin
                    tx_byte_d  = data_q;
                    transmit_d = 1'b1;
                    state_d    = TxGap;
                end
            end
            TxGap: begin
                done_d  = 1'b1;
                state_d = TxIdle;
            end
            default: state_d = TxIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= TxIdle;
            data_q     <= 8'h00;
            tx_byte_q  <= 8'h00;
            transmit_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            tx_byte_q  <= tx_byte_d;
            transmit_q <= transmit_d;
            done_q     <= done_d;
        end
    end

    assign tx_byte  = tx_byte_q;
    assign transmit = transmit_q;
    assign done     = done_q;

endmodule

// File: rtl/boot_monitor.sv
// Serial boot monitor: load/dump RAM over the UART and launch the CPU.
// Define MONITOR_CHECKSUM_EN to append an 8-bit sum byte after load acks and dumps.
module boot_monitor
    import boot_monitor_pkg::*;
#(
    parameter int unsigned addr_width = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_byte,
    input  logic                  received,
    output logic [7:0]            tx_byte,
    output logic                  transmit,
    input  logic                  is_transmitting,
    output logic [addr_width-1:0] m_raddr,
    output logic [addr_width-1:0] m_waddr,
    output logic [7:0]            dwrite,
    output logic                  write_en,
    input  logic [7:0]            dread,
    output logic                  cpu_run,
    output logic [addr_width-1:0] startaddr,
    input  logic                  cpu_halted,
    output logic                  cpu_active
);

`ifdef MONITOR_CHECKSUM_EN
    localparam state_e EndState = StSum;
`else
    localparam state_e EndState = StIdle;
`endif

    state_e                state_q, state_d;
    state_e                ret_q, ret_d;
    logic [addr_width-1:0] addr_q, addr_d;
    logic [addr_width-1:0] m_raddr_q, m_raddr_d;
    logic [addr_width-1:0] startaddr_q, startaddr_d;
    logic [8:0]            len_q, len_d;
    logic [7:0]            cmd_q, cmd_d;
    logic [7:0]            ah_q, ah_d;
    logic [7:0]            data_q, data_d;
    logic                  tx_req_q, tx_req_d;
    logic                  cpu_run_q, cpu_run_d;
    logic                  cpu_active_q, cpu_active_d;
    logic                  tx_done;
    logic                  load_wr;
`ifdef MONITOR_CHECKSUM_EN
    logic [7:0]            sum_q, sum_d;
`endif

    // RAM writes are combinational so each byte lands in its own receive cycle.
    assign load_wr  = (state_q == StLoad) && received;
    assign write_en = load_wr;
    assign m_waddr  = load_wr ? addr_q : '0;
    assign dwrite   = load_wr ? rx_byte : 8'h00;

    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        addr_d       = addr_q;
        m_raddr_d    = m_raddr_q;
        startaddr_d  = startaddr_q;
        len_d        = len_q;
        cmd_d        = cmd_q;
        ah_d         = ah_q;
        data_d       = data_q;
        tx_req_d     = 1'b0;
        cpu_run_d    = 1'b0;
        cpu_active_d = cpu_active_q;
`ifdef MONITOR_CHECKSUM_EN
        sum_d        = sum_q;
`endif
        case (state_q)
            StIdle: begin
                if (received) begin
                    cmd_d = rx_byte;
`ifdef MONITOR_CHECKSUM_EN
                    sum_d = 8'h00;
`endif
                    if (rx_byte == CmdLoad || rx_byte == CmdDump || rx_byte == CmdRun) begin
                        state_d = StAddrHi;
                    end else begin
                        data_d   = RspErr;
                        tx_req_d = 1'b1;
                        ret_d    = StIdle;
                        state_d  = StTxWait;
                    end
                end
            end
            StAddrHi: begin
                if (received) begin
                    ah_d    = rx_byte;
                    state_d = StAddrLo;
                end
            end
            StAddrLo: begin
                if (received) begin
                    if (cmd_q == CmdRun) begin
                        startaddr_d  = addr_width'({ah_q, rx_byte});
                        m_raddr_d    = '0;
                        cpu_run_d    = 1'b1;
                        cpu_active_d = 1'b1;
                        state_d      = StRunStart;
                    end else begin
                        addr_d  = addr_width'({ah_q, rx_byte});
                        state_d = StLen;
                    end
                end
            end
            StLen: begin
                if (received) begin
                    len_d   = decode_len(rx_byte);
                    state_d = (cmd_q == CmdLoad) ? StLoad : StDumpRd;
                end
            end
            StLoad: begin
                if (received) begin
                    addr_d = addr_q + addr_width'(1);
                    len_d  = len_q - 9'd1;
`ifdef MONITOR_CHECKSUM_EN
                    sum_d  = sum_q + rx_byte;
`endif
                    if (len_q == 9'd1) begin
                        data_d   = RspAck;
                        tx_req_d = 1'b1;
                        ret_d    = EndState;
                        state_d  = StTxWait;
                    end
                end
            end
            StDumpRd: begin
                m_raddr_d = addr_q;
                state_d   = StDumpW1;
            end
            StDumpW1: state_d = StDumpW2;
            StDumpW2: state_d = StDumpTx;
            StDumpTx: begin
                data_d   = dread;
`ifdef MONITOR_CHECKSUM_EN
                sum_d    = sum_q + dread;
`endif
                tx_req_d = 1'b1;
                addr_d   = addr_q + addr_width'(1);
                len_d    = len_q - 9'd1;
                ret_d    = (len_q == 9'd1) ? EndState : StDumpRd;
                state_d  = StTxWait;
            end
            // Halt is only honoured once the start pulse has gone out.
            StRunStart: state_d = StRunning;
            StRunning: begin
                if (cpu_halted) begin
                    cpu_active_d = 1'b0;
                    startaddr_d  = '0;
                    data_d       = RspHalt;
                    tx_req_d     = 1'b1;
                    ret_d        = StIdle;
                    state_d      = StTxWait;
                end
            end
            StTxWait: begin
                if (tx_done) state_d = ret_q;
            end
`ifdef MONITOR_CHECKSUM_EN
            StSum: begin
                data_d   = sum_q;
                tx_req_d = 1'b1;
                ret_d    = StIdle;
                state_d  = StTxWait;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            ret_q        <= StIdle;
            addr_q       <= '0;
            m_raddr_q    <= '0;
            startaddr_q  <= '0;
            len_q        <= 9'd0;
            cmd_q        <= 8'h00;
            ah_q         <= 8'h00;
            data_q       <= 8'h00;
            tx_req_q     <= 1'b0;
            cpu_run_q    <= 1'b0;
            cpu_active_q <= 1'b0;
`ifdef MONITOR_CHECKSUM_EN
            sum_q        <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            addr_q       <= addr_d;
            m_raddr_q    <= m_raddr_d;
            startaddr_q  <= startaddr_d;
            len_q        <= len_d;
            cmd_q        <= cmd_d;
            ah_q         <= ah_d;
            data_q       <= data_d;
            tx_req_q     <= tx_req_d;
            cpu_run_q    <= cpu_run_d;
            cpu_active_q <= cpu_active_d;
`ifdef MONITOR_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    mon_tx u_mon_tx (
        .clk             (clk),
        .rst             (rst),
        .req             (tx_req_q),
        .tx_data         (data_q),
        .is_transmitting (is_transmitting),
        .tx_byte         (tx_byte),
        .transmit        (transmit),
        .done            (tx_done)
    );

    assign m_raddr    = m_raddr_q;
    assign startaddr  = startaddr_q;
    assign cpu_run    = cpu_run_q;
    assign cpu_active = cpu_active_q;

endmodule

// File: tb/tb_boot_monitor.sv
// Scoreboard bench for boot_monitor: RAM and UART models, queued expected writes and bytes.
module tb_boot_monitor;

    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rx_byte = 8'h00;
    logic          received = 1'b0;
    logic [7:0]    tx_byte;
    logic          transmit;
    logic          is_transmitting;
    logic [AW-1:0] m_raddr;
    logic [AW-1:0] m_waddr;
    logic [7:0]    dwrite;
    logic          write_en;
    logic [7:0]    dread;
    logic          cpu_run;
    logic [AW-1:0] startaddr;
    logic          cpu_halted = 1'b0;
    logic          cpu_active;

    always #5 clk = ~clk;

    boot_monitor #(.addr_width(AW)) dut (
        .clk             (clk),
        .rst             (rst),
        .rx_byte         (rx_byte),
        .received        (received),
        .tx_byte         (tx_byte),
        .transmit        (transmit),
        .is_transmitting (is_transmitting),
        .m_raddr         (m_raddr),
        .m_waddr         (m_waddr),
        .dwrite          (dwrite),
        .write_en        (write_en),
        .dread           (dread),
        .cpu_run         (cpu_run),
        .startaddr       (startaddr),
        .cpu_halted      (cpu_halted),
        .cpu_active      (cpu_active)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [AW-1:0] exp_wa_q[$];
    logic [7:0]    exp_wd_q[$];
    logic [7:0]    exp_tx_q[$];
    logic [7:0]    ref_mem[512];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // UART busy model: busy for busy_len cycles after each transmit strobe.
    int busy_len = 3;
    int busy_cnt = 0;
    always @(posedge clk) begin
        if (rst) busy_cnt <= 0;
        else if (transmit) busy_cnt <= busy_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign is_transmitting = (busy_cnt != 0);

    // RAM model with two cycles of read latency.
    logic [7:0]    mem[512];
    logic [AW-1:0] rd_addr;
    always @(posedge clk) begin
        if (write_en) mem[m_waddr] <= dwrite;
        rd_addr <= m_raddr;
        dread   <= mem[rd_addr];
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (write_en) begin
                check_eq("wr_pending", 32'(exp_wa_q.size() != 0), 32'd1);
                if (exp_wa_q.size() != 0) begin
                    check_eq("wr_addr", 32'(m_waddr), 32'(exp_wa_q.pop_front()));
                    check_eq("wr_data", 32'(dwrite), 32'(exp_wd_q.pop_front()));
                end
            end
            if (transmit) begin
                check_eq("tx_pending", 32'(exp_tx_q.size() != 0), 32'd1);
                check_eq("tx_busy", 32'(is_transmitting), 32'd0);
                if (exp_tx_q.size() != 0) check_eq("tx_byte", 32'(tx_byte), 32'(exp_tx_q.pop_front()));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_byte  = b;
        received = 1'b1;
        @(posedge clk);
        #1;
        received = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while ((exp_tx_q.size() != 0 || exp_wa_q.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        check_eq(tag, 32'(exp_tx_q.size() + exp_wa_q.size()), 32'd0);
        repeat (8) @(posedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_tx"}, {23'd0, transmit, tx_byte}, 32'd0);
        check_eq({tag, "_wr"}, {14'd0, write_en, dwrite, m_waddr}, 32'd0);
        check_eq({tag, "_raddr"}, 32'(m_raddr), 32'd0);
        check_eq({tag, "_cpu"}, {21'd0, cpu_run, cpu_active, startaddr}, 32'd0);
    endtask

    task automatic do_load(input logic [15:0] a, input int n, input logic [7:0] d[$]);
        logic [7:0] sum = 8'h00;
        for (int i = 0; i < n; i++) sum = sum + d[i];
        exp_tx_q.push_back(8'h2E);
`ifdef MONITOR_CHECKSUM_EN
        exp_tx_q.push_back(sum);
`endif
        send_byte(8'h4C);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            logic [AW-1:0] wa;
            wa = AW'(a + 16'(i));
            exp_wa_q.push_back(wa);
            exp_wd_q.push_back(d[i]);
            ref_mem[wa] = d[i];
            send_byte(d[i]);
        end
    endtask

    task automatic do_dump(input logic [15:0] a, input int n);
        logic [7:0] sum = 8'h00;
        for (int i = 0; i < n; i++) begin
            logic [AW-1:0] ra;
            ra = AW'(a + 16'(i));
            exp_tx_q.push_back(ref_mem[ra]);
            sum = sum + ref_mem[ra];
        end
`ifdef MONITOR_CHECKSUM_EN
        exp_tx_q.push_back(sum);
`endif
        send_byte(8'h44);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
        send_byte(8'(n));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d[$];

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // 256-byte load with N=0
        d = {};
        for (int i = 0; i < 256; i++) d.push_back(8'(i * 7 + 3));
        do_load(16'h0000, 256, d);
        wait_drain("drain_load256", 200);

        d = {8'hAA, 8'hBB, 8'hCC};
        do_load(16'h0010, 3, d);
        wait_drain("drain_load3", 200);

        // Upper address bits ignored, wrap from 0x1FF to 0x000
        d = {8'h11, 8'h22};
        do_load(16'hFFFF & 16'h01FF, 2, d);
        wait_drain("drain_wrap", 200);

        busy_len = 2;
        do_dump(16'h0010, 3);
        wait_drain("drain_dump", 400);

        busy_len = 50;
        do_dump(16'h0010, 3);
        wait_drain("drain_dump_slow", 2000);
        busy_len = 3;

        // Run: halt coincident with cpu_run is ignored, bytes while running dropped
        send_byte(8'h52);
        send_byte(8'h01);
        send_byte(8'h23);
        check_eq("run_pulse", 32'(cpu_run), 32'd1);
        check_eq("run_active", 32'(cpu_active), 32'd1);
        check_eq("run_start", 32'(startaddr), 32'h123);
        cpu_halted = 1'b1;
        @(posedge clk);
        #1;
        cpu_halted = 1'b0;
        check_eq("run_pulse_end", 32'(cpu_run), 32'd0);
        check_eq("run_early_halt", 32'(cpu_active), 32'd1);
        send_byte(8'h7A);
        send_byte(8'h4C);
        repeat (100) @(posedge clk);
        #1;
        check_eq("run_still_active", 32'(cpu_active), 32'd1);
        check_eq("run_hold_addr", 32'(startaddr), 32'h123);
        exp_tx_q.push_back(8'h48);
        cpu_halted = 1'b1;
        @(posedge clk);
        #1;
        cpu_halted = 1'b0;
        @(posedge clk);
        #1;
        check_eq("halt_release", 32'(cpu_active), 32'd0);
        wait_drain("drain_halt", 200);

        exp_tx_q.push_back(8'h3F);
        send_byte(8'h7A);
        wait_drain("drain_err", 200);

        // Reset after the first of three load bytes: no ack, then a clean load
        send_byte(8'h4C);
        send_byte(8'h00);
        send_byte(8'h20);
        send_byte(8'h03);
        exp_wa_q.push_back(AW'(9'h020));
        exp_wd_q.push_back(8'h33);
        ref_mem[9'h020] = 8'h33;
        send_byte(8'h33);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_idle_outputs("midreset");
        rst = 1'b0;
        repeat (2) @(posedge clk);
        d = {8'h77};
        do_load(16'h0030, 1, d);
        wait_drain("drain_after_reset", 200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
